// File: rtl/cpu_pkg.sv
// Shared types and helpers for the PC / branch-resolution slice of the 16-bit core.
package cpu_pkg;

    localparam logic [2:0] COND_NE = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_GT = 3'b010;
    localparam logic [2:0] COND_LT = 3'b011;
    localparam logic [2:0] COND_GE = 3'b100;
    localparam logic [2:0] COND_LE = 3'b101;
    localparam logic [2:0] COND_OV = 3'b110;
    localparam logic [2:0] COND_UN = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

    // Saturating 16-bit increment used by the branch statistics counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/br_target_add.sv
// Ripple-carry 16-bit adder for PC-relative branch targets, with signed overflow flag.
module br_target_add
    import cpu_pkg::*;
(
    input  logic [15:0] pc_plus2,
    input  logic [15:0] offset,
    output logic [15:0] target,
    output logic        tgt_ovfl
);

    logic [16:0] carry_s;
    logic [15:0] sum_s;
    logic [1:0]  cell_s;

    // Chain the full-adder cells from bit 0 upward.
    always_comb begin
        carry_s    = 17'd0;
        sum_s      = 16'd0;
        cell_s     = 2'd0;
        for (int i = 0; i < 16; i++) begin
            cell_s         = full_add(pc_plus2[i], offset[i], carry_s[i]);
            sum_s[i]       = cell_s[0];
            carry_s[i + 1] = cell_s[1];
        end
    end

    assign target   = sum_s;
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign tgt_ovfl = carry_s[16] ^ carry_s[15];

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC register, branch condition evaluation and redirect/flush/halt control.
// Optional branch statistics counters are built when PC_BRANCH_CTRL_STATS_EN is defined.
module pc_branch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_reg,
    input  logic [2:0]  cond,
    input  logic [2:0]  flags,
    input  logic [8:0]  imm9,
    input  logic [15:0] reg_tgt,
    input  logic        halt_in,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        taken,
    output logic        flush,
    output logic        tgt_ovfl,
    output logic        halted
`ifdef PC_BRANCH_CTRL_STATS_EN
   ,output logic [15:0] br_taken_cnt,
    output logic [15:0] br_total_cnt
`endif
);

    pc_state_t   state_r, state_next_s;
    logic [15:0] pc_r, pc_next_s, pc_plus2_s;
    logic [15:0] offset_s, add_tgt_s, target_s;
    logic        flush_r, halted_r;
    logic        cond_true_s, taken_s, add_ovfl_s;
    logic        unused_reg_tgt_s;

    assign pc_plus2_s       = pc_r + 16'd2;
    assign offset_s         = {{6{imm9[8]}}, imm9, 1'b0};
    assign unused_reg_tgt_s = reg_tgt[0];

    br_target_add u_add (
        .pc_plus2 (pc_plus2_s),
        .offset   (offset_s),
        .target   (add_tgt_s),
        .tgt_ovfl (add_ovfl_s)
    );

    // Evaluate the condition code against the latched {Z,V,N} flags.
    always_comb begin
        cond_true_s = 1'b0;
        case (cond)
            COND_NE: cond_true_s = ~flags[FLAG_Z];
            COND_EQ: cond_true_s = flags[FLAG_Z];
            COND_GT: cond_true_s = ~flags[FLAG_Z] & ~flags[FLAG_N];
            COND_LT: cond_true_s = flags[FLAG_N];
            COND_GE: cond_true_s = flags[FLAG_Z] | (~flags[FLAG_Z] & ~flags[FLAG_N]);
            COND_LE: cond_true_s = flags[FLAG_N] | flags[FLAG_Z];
            COND_OV: cond_true_s = flags[FLAG_V];
            COND_UN: cond_true_s = 1'b1;
            default: cond_true_s = 1'b0;
        endcase
    end

    // A branch in the squashed slot after a redirect, or alongside HLT, never resolves taken.
    assign taken_s  = ~rst & br_valid & cond_true_s & ~stall & (state_r == RUN) & ~halt_in;
    assign target_s = br_reg ? {reg_tgt[15:1], 1'b0} : add_tgt_s;

    // Next-PC selection and FSM transition.
    always_comb begin
        pc_next_s    = pc_r;
        state_next_s = state_r;
        if (stall) begin
            pc_next_s    = pc_r;
            state_next_s = state_r;
        end else begin
            if ((state_r == HALT) || halt_in) begin
                pc_next_s = pc_r;
            end else if (taken_s) begin
                pc_next_s = target_s;
            end else begin
                pc_next_s = pc_plus2_s;
            end
            case (state_r)
                RUN: begin
                    if (halt_in) begin
                        state_next_s = HALT;
                    end else if (taken_s) begin
                        state_next_s = FLUSH;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                FLUSH:   state_next_s = RUN;
                HALT:    state_next_s = HALT;
                default: state_next_s = RUN;
            endcase
        end
    end

    // PC, FSM state and state-decoded outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            state_r  <= RUN;
            flush_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            state_r  <= state_next_s;
            flush_r  <= (state_next_s == FLUSH);
            halted_r <= (state_next_s == HALT);
        end
    end

    assign pc       = pc_r;
    assign pc_plus2 = pc_plus2_s;
    assign taken    = taken_s;
    assign flush    = flush_r;
    assign halted   = halted_r;
    assign tgt_ovfl = ~rst & br_valid & ~br_reg & add_ovfl_s;

`ifdef PC_BRANCH_CTRL_STATS_EN
    logic [15:0] taken_cnt_r, total_cnt_r;

    // Saturating counters of branches seen in unstalled RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_r <= 16'd0;
            total_cnt_r <= 16'd0;
        end else if (~stall && (state_r == RUN) && br_valid) begin
            total_cnt_r <= sat_inc(total_cnt_r);
            taken_cnt_r <= taken_s ? sat_inc(taken_cnt_r) : taken_cnt_r;
        end else begin
            taken_cnt_r <= taken_cnt_r;
            total_cnt_r <= total_cnt_r;
        end
    end

    assign br_taken_cnt = taken_cnt_r;
    assign br_total_cnt = total_cnt_r;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pc_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br_valid = 1'b0, br_reg = 1'b0, halt_in = 1'b0;
    logic [2:0]  cond = 3'd0, flags = 3'd0;
    logic [8:0]  imm9 = 9'd0;
    logic [15:0] reg_tgt = 16'd0;
    logic [15:0] pc, pc_plus2;
    logic        taken, flush, tgt_ovfl, halted;
`ifdef PC_BRANCH_CTRL_STATS_EN
    logic [15:0] br_taken_cnt, br_total_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int m_pc = 0;
    bit m_flush = 1'b0;
    bit m_halt = 1'b0;
    int m_tot = 0;
    int m_tk = 0;

    pc_branch_ctrl #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_reg(br_reg),
        .cond(cond), .flags(flags), .imm9(imm9), .reg_tgt(reg_tgt), .halt_in(halt_in),
        .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .flush(flush),
        .tgt_ovfl(tgt_ovfl), .halted(halted)
`ifdef PC_BRANCH_CTRL_STATS_EN
       ,.br_taken_cnt(br_taken_cnt), .br_total_cnt(br_total_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int soff();
        return imm9[8] ? (int'(imm9) - 512) : int'(imm9);
    endfunction

    function automatic bit exp_taken();
        return !rst && br_valid && cond_ok(cond, flags) && !stall && !m_flush && !m_halt && !halt_in;
    endfunction

    function automatic int exp_target();
        if (br_reg) return int'(reg_tgt) & 32'hFFFE;
        return (m_pc + 2 + soff() * 2) & 32'hFFFF;
    endfunction

    function automatic bit exp_ovfl();
        int a, sa, s;
        if (rst || !br_valid || br_reg) return 1'b0;
        a = (m_pc + 2) & 32'hFFFF;
        sa = (a >= 32768) ? a - 65536 : a;
        s = sa + soff() * 2;
        return (s > 32767) || (s < -32768);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_flush = 1'b0; m_halt = 1'b0; m_tot = 0; m_tk = 0;
    endtask

    task automatic model_step();
        bit t;
        int tg;
        if (rst) begin
            model_reset();
        end else if (!stall) begin
            t = exp_taken();
            tg = exp_target();
            if (br_valid && !m_flush && !m_halt) begin
                if (m_tot < 65535) m_tot++;
                if (t && m_tk < 65535) m_tk++;
            end
            if (m_halt || halt_in) m_pc = m_pc;
            else if (t) m_pc = tg;
            else m_pc = (m_pc + 2) & 32'hFFFF;
            if (m_halt) m_halt = 1'b1;
            else if (m_flush) m_flush = 1'b0;
            else if (halt_in) m_halt = 1'b1;
            else if (t) m_flush = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_valid = 1'b0; stall = 1'b0; halt_in = 1'b0;
    endtask

    // Land in RUN at addr via an unconditional BR followed by the squashed slot.
    task automatic goto(input logic [15:0] addr);
        idle();
        tick();
        br_valid = 1'b1; br_reg = 1'b1; cond = 3'd7; reg_tgt = addr - 16'd2;
        tick();
        br_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; br_valid = 1'b1; cond = 3'd7; br_reg = 1'b0; imm9 = 9'h0FF;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pc); end
        n_cmp++; if (flush !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_flags flush=%b halted=%b want 0 0", flush, halted); end
        n_cmp++; if (taken !== 1'b0 || tgt_ovfl !== 1'b0) begin n_fail++; $display("FAIL reset_comb taken=%b ovfl=%b want 0 0", taken, tgt_ovfl); end
        idle();
        rst = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++; if (pc !== 16'(2 * i)) begin n_fail++; $display("FAIL reset_step%0d got %h want %h", i, pc, 16'(2 * i)); end
        end
        // asynchronous reset while in FLUSH
        br_valid = 1'b1; br_reg = 1'b1; cond = 3'd7; reg_tgt = 16'h0300;
        tick();
        br_valid = 1'b0;
        #2 rst = 1'b1; model_reset();
        #1;
        n_cmp++; if (pc !== 16'h0000 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flush pc=%h flush=%b want 0000 0", pc, flush); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_taken_b();
        goto(16'h0010);
        br_valid = 1'b1; br_reg = 1'b0; cond = 3'd1; flags = 3'b100; imm9 = 9'h004;
        #1;
        n_cmp++; if (taken !== 1'b1) begin n_fail++; $display("FAIL takenb_taken got %b want 1", taken); end
        tick();
        n_cmp++; if (pc !== 16'h001A || flush !== 1'b1) begin n_fail++; $display("FAIL takenb_redirect pc=%h flush=%b want 001a 1", pc, flush); end
        #1;
        n_cmp++; if (taken !== 1'b0) begin n_fail++; $display("FAIL takenb_squash taken got %b want 0", taken); end
        tick();
        n_cmp++; if (pc !== 16'h001C || flush !== 1'b0) begin n_fail++; $display("FAIL takenb_after pc=%h flush=%b want 001c 0", pc, flush); end
        idle();
    endtask

    task automatic test_not_taken_neg();
        goto(16'h0020);
        br_valid = 1'b1; br_reg = 1'b0; cond = 3'd3; flags = 3'b000; imm9 = 9'h1FC;
        tick();
        n_cmp++; if (pc !== 16'h0022 || flush !== 1'b0) begin n_fail++; $display("FAIL nottaken pc=%h flush=%b want 0022 0", pc, flush); end
        goto(16'h0020);
        br_valid = 1'b1; br_reg = 1'b0; cond = 3'd3; flags = 3'b001; imm9 = 9'h1FC;
        tick();
        n_cmp++; if (pc !== 16'h001A || flush !== 1'b1) begin n_fail++; $display("FAIL negoff pc=%h flush=%b want 001a 1", pc, flush); end
        idle();
    endtask

    task automatic test_overflow();
        goto(16'h7FFC);
        br_valid = 1'b1; br_reg = 1'b0; cond = 3'd7; imm9 = 9'h0FF;
        #1;
        n_cmp++; if (tgt_ovfl !== 1'b1 || taken !== 1'b1) begin n_fail++; $display("FAIL ovfl_flag ovfl=%b taken=%b want 1 1", tgt_ovfl, taken); end
        tick();
        n_cmp++; if (pc !== 16'h81FC) begin n_fail++; $display("FAIL ovfl_wrap got %h want 81fc", pc); end
        idle();
    endtask

    task automatic test_stall_halt();
        goto(16'h0040);
        stall = 1'b1; br_valid = 1'b1; br_reg = 1'b0; cond = 3'd7; imm9 = 9'h010;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (taken !== 1'b0) begin n_fail++; $display("FAIL stall_taken%0d got %b want 0", i, taken); end
            tick();
            n_cmp++; if (pc !== 16'h0040 || flush !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d pc=%h flush=%b want 0040 0", i, pc, flush); end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (pc !== 16'h0062 || flush !== 1'b1) begin n_fail++; $display("FAIL stall_release pc=%h flush=%b want 0062 1", pc, flush); end
        stall = 1'b1;
        tick(); tick();
        n_cmp++; if (pc !== 16'h0062 || flush !== 1'b1) begin n_fail++; $display("FAIL stall_in_flush pc=%h flush=%b want 0062 1", pc, flush); end
        stall = 1'b0;
        tick();
        n_cmp++; if (pc !== 16'h0064 || flush !== 1'b0) begin n_fail++; $display("FAIL flush_once pc=%h flush=%b want 0064 0", pc, flush); end
        goto(16'h0050);
        halt_in = 1'b1; br_valid = 1'b1; br_reg = 1'b1; cond = 3'd7; reg_tgt = 16'h0100;
        #1;
        n_cmp++; if (taken !== 1'b0) begin n_fail++; $display("FAIL halt_taken got %b want 0", taken); end
        tick();
        halt_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pc !== 16'h0050 || halted !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_hold%0d pc=%h halted=%b flush=%b want 0050 1 0", i, pc, halted, flush); end
            tick();
        end
        rst = 1'b1; model_reset();
        #1;
        n_cmp++; if (halted !== 1'b0 || pc !== 16'h0000) begin n_fail++; $display("FAIL halt_reset halted=%b pc=%h want 0 0000", halted, pc); end
        idle();
        tick();
        rst = 1'b0;
    endtask

`ifdef PC_BRANCH_CTRL_STATS_EN
    task automatic test_stats();
        rst = 1'b1; model_reset(); idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1; br_valid = 1'b1; br_reg = 1'b0; cond = 3'd7; imm9 = 9'h008;
            tick();
            stall = 1'b0; flags = 3'b000; cond = (i == 1 || i == 3) ? 3'd6 : 3'd7;
            tick();
            br_valid = 1'b0;
            tick();
        end
        n_cmp++; if (br_total_cnt !== 16'd5) begin n_fail++; $display("FAIL stats_total got %0d want 5", br_total_cnt); end
        n_cmp++; if (br_taken_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_taken got %0d want 3", br_taken_cnt); end
    endtask
`endif

    task automatic test_random();
        rst = 1'b1; model_reset(); idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(99) == 0) || (m_halt && $urandom_range(7) == 0);
            stall    = ($urandom_range(3) == 0);
            br_valid = $urandom_range(1);
            br_reg   = $urandom_range(1);
            cond     = 3'($urandom);
            flags    = 3'($urandom);
            imm9     = 9'($urandom);
            reg_tgt  = 16'($urandom);
            halt_in  = ($urandom_range(63) == 0);
            if (rst) model_reset();
            #1;
            n_cmp++; if (taken !== exp_taken()) begin n_fail++; $display("FAIL rnd_taken it%0d got %b want %b", i, taken, exp_taken()); end
            n_cmp++; if (tgt_ovfl !== exp_ovfl()) begin n_fail++; $display("FAIL rnd_ovfl it%0d got %b want %b", i, tgt_ovfl, exp_ovfl()); end
            n_cmp++; if (pc_plus2 !== 16'(m_pc + 2)) begin n_fail++; $display("FAIL rnd_pcp2 it%0d got %h want %h", i, pc_plus2, 16'(m_pc + 2)); end
            tick();
            n_cmp++; if (pc !== 16'(m_pc)) begin n_fail++; $display("FAIL rnd_pc it%0d got %h want %h", i, pc, 16'(m_pc)); end
            n_cmp++; if (flush !== m_flush || halted !== m_halt) begin n_fail++; $display("FAIL rnd_state it%0d flush=%b halted=%b want %b %b", i, flush, halted, m_flush, m_halt); end
`ifdef PC_BRANCH_CTRL_STATS_EN
            n_cmp++; if (br_total_cnt !== 16'(m_tot) || br_taken_cnt !== 16'(m_tk)) begin n_fail++; $display("FAIL rnd_cnt it%0d tot=%0d tk=%0d want %0d %0d", i, br_total_cnt, br_taken_cnt, m_tot, m_tk); end
`endif
        end
        rst = 1'b0; idle();
    endtask

    initial begin
        test_reset();
        test_taken_b();
        test_not_taken_neg();
        test_overflow();
        test_stall_halt();
`ifdef PC_BRANCH_CTRL_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter and branch-resolution block for the 16-bit pipelined core. It owns the PC register and evaluates branch conditions against the latched {Z,V,N} flags. It forms the redirect target as PC-relative (B) or register (BR) and issues a one-cycle flush to the fetch/decode stages on a taken branch. It consumes the same 16-bit two's-complement branch-target arithmetic the datapath uses, and stops fetch on HLT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; freezes PC and FSM.
- br_valid  in  1  decode stage holds a branch this cycle.
- br_reg  in  1  1 = BR (register target), 0 = B (PC-relative).
- cond  in  3  condition code.
- flags  in  3  {Z,V,N} from flag register.
- imm9  in  9  signed branch offset in halfwords.
- reg_tgt  in  16  register target for BR.
- halt_in  in  1  HLT decoded.
- pc  out  16  current fetch address.
- pc_plus2  out  16  pc + 2 (wraps).
- taken  out  1  branch resolved taken this cycle (combinational).
- flush  out  1  registered one-cycle flush of IF/ID.
- tgt_ovfl  out  1  PC-relative target overflowed (combinational, informational).
- halted  out  1  fetch stopped.

## Operation
- Condition decode: 000 NE (!Z), 001 EQ (Z), 010 GT (!Z & !N), 011 LT (N), 100 GE (Z | (!Z & !N)), 101 LE (N | Z), 110 OV (V), 111 always.
- taken = br_valid & cond_true & !stall & state==RUN & !halt_in.
- B target = pc_plus2 + (sext(imm9) << 1), mod 2^16.
- tgt_ovfl: the two addends have equal sign and the sum sign differs. The target still wraps; there is no trap.
- BR target = reg_tgt; bit 0 is forced to 0.
- Next PC in priority order:
  - rst: RESET_PC.
  - stall: hold.
  - halted or halt_in: hold.
  - taken: target.
  - otherwise: pc_plus2.
- FSM states:
  - RUN → FLUSH when taken.
  - RUN → HALT when halt_in & !stall.
  - FLUSH → RUN after one unstalled cycle; br_valid is ignored in FLUSH, since it is a squashed slot.
  - HALT is terminal until rst.
- Outputs by state: flush = (state==FLUSH); halted = (state==HALT).
- Same-cycle halt_in and br_valid: halt wins, PC holds, no flush.
- Stall during FLUSH: stay in FLUSH with flush held high.

## Timing
- Reset values: pc=RESET_PC, state=RUN, flush=0, halted=0, taken=0, tgt_ovfl=0, counters=0.
- Resolution latency is zero: taken in cycle N gives pc=target and flush=1 in cycle N+1.
- Taken branch penalty: one squashed fetch.
- The PC register is the only state besides the FSM and the optional counters. All outputs other than taken/tgt_ovfl/pc_plus2 are registered.
- Reset asserted mid-FLUSH or in HALT returns the block to RUN at RESET_PC asynchronously.

## Configuration
- Macro: PC_BRANCH_CTRL_STATS_EN.
- Defined:
  - Adds outputs br_taken_cnt[15:0] and br_total_cnt[15:0].
  - On each unstalled RUN cycle with br_valid, br_total_cnt increments, and br_taken_cnt increments if taken.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and logic are absent; the block is otherwise identical.

## Structure
- Shared package cpu_pkg holds:
  - condition-code localparams (COND_NE … COND_UN);
  - state enum pc_state_t {RUN, FLUSH, HALT};
  - FLAG_Z/V/N bit indices.
- Sub-module br_target_add: combinational 16-bit adder with overflow, built from 1-bit full-adder cells. Inputs are pc_plus2 and the shifted sext offset; outputs are target and tgt_ovfl. pc_plus2 uses a separate plain increment.

## Test plan
- Reset: assert rst mid-run → pc=16'h0000, flush=0, halted=0. Release → pc steps 0,2,4 on successive cycles.
- Taken B: pc=16'h0010, cond=001, flags Z=1, imm9=9'h004 → next pc=16'h001A, flush=1 for exactly one cycle. A br_valid during FLUSH is ignored.
- Not taken plus negative offset:
  - pc=16'h0020, cond=011, N=0 → pc=16'h0022, no flush.
  - Repeat with N=1, imm9=9'h1FC → pc=16'h001A.
- Overflow wrap: pc=16'h7FFC, cond=111, imm9=9'h0FF → pc=16'h81FC, tgt_ovfl=1 in the resolve cycle.
- Stall and halt:
  - Stall held 3 cycles with a taken branch present → pc frozen, no flush. On release, the redirect happens once.
  - halt_in together with a taken BR → pc holds, halted=1 forever until rst.
- Stats (macro defined): 5 branches with 3 taken → br_total_cnt=5, br_taken_cnt=3. Stalled cycles are not counted.
